// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the access-legality helpers used at request decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR,
    RESP
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Stores only have B/H/W encodings; loads add the unsigned B/H variants.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    logic ill;
    if (we) begin
      ill = funct3[2] || (funct3[1:0] == 2'b11);
    end else begin
      ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    return ill;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the request, response and data-memory signals of the load/store
// unit; the slave modport is the unit's own view.
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] mem_addr;
  logic        mem_r_enable;
  logic        mem_w_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_r_enable, mem_w_enable, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_r_enable, mem_w_enable, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a memory word
// and merges sub-word store data into a read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ext_rdata,
  output logic [31:0] o_merged_wdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_ext_rdata = '0;
    case (i_funct3)
      F3_B:    o_ext_rdata = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_ext_rdata = {{16{w_half[15]}}, w_half};
      F3_W:    o_ext_rdata = i_rdata;
      F3_BU:   o_ext_rdata = {24'h0, w_byte};
      F3_HU:   o_ext_rdata = {16'h0, w_half};
      default: o_ext_rdata = '0;
    endcase
  end

  // Only SB/SH reach the merge path, so a full-word code just passes wdata.
  always_comb begin
    o_merged_wdata = i_rdata;
    case (i_funct3[1:0])
      2'b00:   o_merged_wdata[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
      2'b01:   o_merged_wdata[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merged_wdata = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-side load/store unit: turns RV32I byte/half/word accesses into word
// reads, word writes and read-modify-write sequences on a word memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);

  localparam logic [2:0] LP_LAT = 3'(MEM_RD_LATENCY);

  lsu_state_t  r_state;
  lsu_state_t  w_next_state;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [2:0]  r_funct3;
  logic [2:0]  r_cnt;
  logic        r_we;
  logic        r_err;

  logic        w_accept;
  logic        w_req_err;
  logic        w_sample;
  logic [31:0] w_ext_rdata;
  logic [31:0] w_merged_wdata;

  // Accept is derived from state directly rather than from req_ready to keep
  // the output block free of a combinational self-loop.
  assign w_accept  = bus.req_valid && rst_n && (r_state == IDLE);
  assign w_req_err = is_illegal(bus.req_we, bus.req_funct3) ||
                     is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
  assign w_sample  = (r_state == RD_WAIT) && (r_cnt == 3'd1);

  lsu_align u_align (
    .i_funct3       (r_funct3),
    .i_addr_lo      (r_addr[1:0]),
    .i_rdata        (bus.mem_rdata),
    .i_wdata        (r_wdata),
    .o_ext_rdata    (w_ext_rdata),
    .o_merged_wdata (w_merged_wdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    bus.req_ready    = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_rdata    = '0;
    bus.rsp_err      = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_r_enable = 1'b0;
    bus.mem_w_enable = 1'b0;
    bus.mem_wdata    = '0;

    case (r_state)
      IDLE: begin
        bus.req_ready = rst_n;
        if (w_accept) begin
          if (w_req_err) begin
            w_next_state = RESP;
          end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
            w_next_state = WR;
          end else begin
            w_next_state = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        bus.mem_r_enable = 1'b1;
        bus.mem_addr     = {r_addr[31:2], 2'b00};
        w_next_state     = RD_WAIT;
      end
      RD_WAIT: begin
        if (w_sample) begin
          w_next_state = r_we ? WR : RESP;
        end
      end
      WR: begin
        bus.mem_w_enable = 1'b1;
        bus.mem_addr     = {r_addr[31:2], 2'b00};
        bus.mem_wdata    = r_wdata;
        w_next_state     = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = r_rdata;
        bus.rsp_err   = r_err;
        if (bus.rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // r_wdata doubles as the write buffer: SW keeps the request data, SB/SH
  // overwrite it with the merged word before the WR cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_funct3 <= '0;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr   <= bus.req_addr;
        r_funct3 <= bus.req_funct3;
        r_we     <= bus.req_we;
        r_wdata  <= bus.req_wdata;
        r_err    <= w_req_err;
        r_rdata  <= '0;
      end
      if (r_state == RD_REQ) begin
        r_cnt <= LP_LAT;
      end else if (r_state == RD_WAIT) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_sample) begin
        if (r_we) begin
          r_wdata <= w_merged_wdata;
        end else begin
          r_rdata <= w_ext_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: two instances (read latency 1 and 3),
// each backed by a small word-memory model with strobe monitors.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic preload;
  int   checks = 0;
  int   errors = 0;

  lsu_if bus1();
  lsu_if bus3();

  load_store_unit #(.MEM_RD_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  load_store_unit #(.MEM_RD_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  always #5 clk = ~clk;

  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] pipe1 = 32'hDEADBEEF;
  logic [31:0] pipe3a = 32'hDEADBEEF, pipe3b = 32'hDEADBEEF, pipe3c = 32'hDEADBEEF;
  int rdCount1 = 0, wrCount1 = 0, bothHigh1 = 0, badIdle1 = 0;
  int rdCount3 = 0, wrCount3 = 0, bothHigh3 = 0;
  logic [31:0] lastRdAddr1 = '0, lastWrAddr1 = '0, lastWrData1 = '0, lastRdAddr3 = '0;

  assign bus1.mem_rdata = pipe1;
  assign bus3.mem_rdata = pipe3c;

  // Memory models: read data is only meaningful in the latency slot, garbage otherwise.
  always @(posedge clk) begin
    if (preload) begin
      mem1[64]  <= 32'h8899AABB;
      mem1[128] <= 32'h11223344;
      mem1[129] <= 32'h00000000;
      mem3[64]  <= 32'h8899AABB;
    end else begin
      if (bus1.mem_w_enable) mem1[bus1.mem_addr[9:2]] <= bus1.mem_wdata;
      if (bus3.mem_w_enable) mem3[bus3.mem_addr[9:2]] <= bus3.mem_wdata;
    end
    pipe1  <= bus1.mem_r_enable ? mem1[bus1.mem_addr[9:2]] : 32'hDEADBEEF;
    pipe3a <= bus3.mem_r_enable ? mem3[bus3.mem_addr[9:2]] : 32'hDEADBEEF;
    pipe3b <= pipe3a;
    pipe3c <= pipe3b;
  end

  always @(posedge clk) begin
    if (bus1.mem_r_enable) begin rdCount1 <= rdCount1 + 1; lastRdAddr1 <= bus1.mem_addr; end
    if (bus1.mem_w_enable) begin
      wrCount1 <= wrCount1 + 1; lastWrAddr1 <= bus1.mem_addr; lastWrData1 <= bus1.mem_wdata;
    end
    if (bus1.mem_r_enable && bus1.mem_w_enable) bothHigh1 <= bothHigh1 + 1;
    if (!bus1.mem_r_enable && !bus1.mem_w_enable && (bus1.mem_addr != 0 || bus1.mem_wdata != 0))
      badIdle1 <= badIdle1 + 1;
    if (bus3.mem_r_enable) begin rdCount3 <= rdCount3 + 1; lastRdAddr3 <= bus3.mem_addr; end
    if (bus3.mem_w_enable) wrCount3 <= wrCount3 + 1;
    if (bus3.mem_r_enable && bus3.mem_w_enable) bothHigh3 <= bothHigh3 + 1;
  end

  // Drives one request on the latency-1 instance and returns the cycle count
  // from accept to first rsp_valid, plus the response fields.
  task automatic issue1(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic early,
                        output int lat, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    bus1.req_valid  = 1'b1;
    bus1.req_we     = we;
    bus1.req_funct3 = f3;
    bus1.req_addr   = addr;
    bus1.req_wdata  = wdata;
    bus1.rsp_ready  = early;
    @(posedge clk);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    lat = 1;
    while (!bus1.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = bus1.rsp_rdata;
    err   = bus1.rsp_err;
    bus1.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    preload = 1'b0;
    checks++; if (bus1.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_ready: got %b expected 0", bus1.req_ready); end
    checks++; if (bus1.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp_valid: got %b expected 0", bus1.rsp_valid); end
    checks++; if ({bus1.mem_r_enable, bus1.mem_w_enable} !== 2'b00) begin errors++; $display("[TB] FAIL rst_strobes: got %b%b expected 00", bus1.mem_r_enable, bus1.mem_w_enable); end
    checks++; if (bus1.mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_mem_addr: got %h expected 0", bus1.mem_addr); end
    checks++; if ({bus1.rsp_rdata, bus1.rsp_err} !== 33'h0) begin errors++; $display("[TB] FAIL rst_rsp: got %h/%b expected 0/0", bus1.rsp_rdata, bus1.rsp_err); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus1.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_req_ready: got %b expected 1", bus1.req_ready); end
  endtask

  task automatic test_loads();
    logic [31:0] addrs [5];
    logic [2:0]  f3s [5];
    logic [31:0] exps [5];
    int lat, rd0, wr0;
    logic [31:0] rdata;
    logic err;
    addrs = '{32'h101, 32'h102, 32'h102, 32'h100, 32'h100};
    f3s   = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b010};
    exps  = '{32'hFFFFFFAA, 32'h00008899, 32'hFFFF8899, 32'h000000BB, 32'h8899AABB};
    for (int i = 0; i < 5; i++) begin
      rd0 = rdCount1; wr0 = wrCount1;
      issue1(1'b0, f3s[i], addrs[i], 32'h0, 1'b0, lat, rdata, err);
      checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL load%0d_latency: got %0d expected 3", i, lat); end
      checks++; if (rdata !== exps[i]) begin errors++; $display("[TB] FAIL load%0d_data: got %h expected %h", i, rdata, exps[i]); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL load%0d_err: got %b expected 0", i, err); end
      checks++; if (rdCount1 !== rd0 + 1 || wrCount1 !== wr0) begin errors++; $display("[TB] FAIL load%0d_strobes: got rd %0d wr %0d expected rd %0d wr %0d", i, rdCount1 - rd0, wrCount1 - wr0, 1, 0); end
      checks++; if (lastRdAddr1 !== 32'h100) begin errors++; $display("[TB] FAIL load%0d_addr: got %h expected 00000100", i, lastRdAddr1); end
    end
  endtask

  task automatic test_store_rmw();
    int lat, rd0, wr0;
    logic [31:0] rdata;
    logic err;
    rd0 = rdCount1; wr0 = wrCount1;
    issue1(1'b1, 3'b000, 32'h203, 32'h000000EE, 1'b0, lat, rdata, err);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL sb_latency: got %0d expected 4", lat); end
    checks++; if (rdCount1 !== rd0 + 1 || wrCount1 !== wr0 + 1) begin errors++; $display("[TB] FAIL sb_strobes: got rd %0d wr %0d expected 1 1", rdCount1 - rd0, wrCount1 - wr0); end
    checks++; if (lastWrAddr1 !== 32'h200) begin errors++; $display("[TB] FAIL sb_wr_addr: got %h expected 00000200", lastWrAddr1); end
    checks++; if (lastWrData1 !== 32'hEE223344) begin errors++; $display("[TB] FAIL sb_wr_data: got %h expected ee223344", lastWrData1); end
    checks++; if ({rdata, err} !== 33'h0) begin errors++; $display("[TB] FAIL sb_rsp: got %h/%b expected 0/0", rdata, err); end
    issue1(1'b0, 3'b010, 32'h200, 32'h0, 1'b0, lat, rdata, err);
    checks++; if (rdata !== 32'hEE223344) begin errors++; $display("[TB] FAIL sb_readback: got %h expected ee223344", rdata); end
    issue1(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1'b0, lat, rdata, err);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL sh_latency: got %0d expected 4", lat); end
    checks++; if (lastWrData1 !== 32'hABCD3344) begin errors++; $display("[TB] FAIL sh_wr_data: got %h expected abcd3344", lastWrData1); end
    issue1(1'b0, 3'b001, 32'h202, 32'h0, 1'b0, lat, rdata, err);
    checks++; if (rdata !== 32'hFFFFABCD) begin errors++; $display("[TB] FAIL sh_readback: got %h expected ffffabcd", rdata); end
  endtask

  task automatic test_sw();
    int lat, rd0, wr0;
    logic [31:0] rdata;
    logic err;
    rd0 = rdCount1; wr0 = wrCount1;
    issue1(1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 1'b0, lat, rdata, err);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL sw_latency: got %0d expected 2", lat); end
    checks++; if (rdCount1 !== rd0 || wrCount1 !== wr0 + 1) begin errors++; $display("[TB] FAIL sw_strobes: got rd %0d wr %0d expected 0 1", rdCount1 - rd0, wrCount1 - wr0); end
    checks++; if (lastWrAddr1 !== 32'h204 || lastWrData1 !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL sw_write: got %h@%h expected cafef00d@00000204", lastWrData1, lastWrAddr1); end
    issue1(1'b0, 3'b010, 32'h204, 32'h0, 1'b0, lat, rdata, err);
    checks++; if (rdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL sw_readback: got %h expected cafef00d", rdata); end
  endtask

  task automatic test_errors();
    logic        wes [6];
    logic [2:0]  f3s [6];
    logic [31:0] addrs [6];
    int lat, rd0, wr0;
    logic [31:0] rdata;
    logic err;
    wes   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    f3s   = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b011, 3'b010};
    addrs = '{32'h103, 32'h102, 32'h100, 32'h200, 32'h200, 32'h201};
    for (int i = 0; i < 6; i++) begin
      rd0 = rdCount1; wr0 = wrCount1;
      issue1(wes[i], f3s[i], addrs[i], 32'hFFFFFFFF, 1'b0, lat, rdata, err);
      checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL err%0d_latency: got %0d expected 1", i, lat); end
      checks++; if (err !== 1'b1 || rdata !== 32'h0) begin errors++; $display("[TB] FAIL err%0d_rsp: got %h/%b expected 0/1", i, rdata, err); end
      checks++; if (rdCount1 !== rd0 || wrCount1 !== wr0) begin errors++; $display("[TB] FAIL err%0d_strobes: got rd %0d wr %0d expected 0 0", i, rdCount1 - rd0, wrCount1 - wr0); end
    end
    issue1(1'b0, 3'b000, 32'h103, 32'h0, 1'b0, lat, rdata, err);
    checks++; if (err !== 1'b0 || rdata !== 32'hFFFFFF88) begin errors++; $display("[TB] FAIL lb_top_lane: got %h/%b expected ffffff88/0", rdata, err); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] rdata;
    logic err;
    issue1(1'b0, 3'b100, 32'h103, 32'h0, 1'b1, lat, rdata, err);
    checks++; if (lat !== 3 || rdata !== 32'h00000088) begin errors++; $display("[TB] FAIL early_ready_lbu: got %0d/%h expected 3/00000088", lat, rdata); end
    issue1(1'b0, 3'b101, 32'h100, 32'h0, 1'b1, lat, rdata, err);
    checks++; if (lat !== 3 || rdata !== 32'h0000AABB) begin errors++; $display("[TB] FAIL early_ready_lhu: got %0d/%h expected 3/0000aabb", lat, rdata); end
  endtask

  task automatic test_latency3();
    int lat;
    @(negedge clk);
    checks++; if (bus3.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL lat3_ready: got %b expected 1", bus3.req_ready); end
    bus3.req_valid = 1'b1; bus3.req_we = 1'b0; bus3.req_funct3 = 3'b010;
    bus3.req_addr = 32'h100; bus3.req_wdata = 32'h0; bus3.rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus3.req_valid = 1'b0;
    lat = 1;
    while (!bus3.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL lat3_latency: got %0d expected 5", lat); end
    checks++; if (bus3.rsp_rdata !== 32'h8899AABB) begin errors++; $display("[TB] FAIL lat3_data: got %h expected 8899aabb", bus3.rsp_rdata); end
    checks++; if (rdCount3 !== 1 || wrCount3 !== 0 || lastRdAddr3 !== 32'h100) begin errors++; $display("[TB] FAIL lat3_strobes: got rd %0d wr %0d addr %h expected 1 0 00000100", rdCount3, wrCount3, lastRdAddr3); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus3.rsp_valid !== 1'b1 || bus3.rsp_rdata !== 32'h8899AABB || bus3.req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL lat3_hold%0d: got valid %b data %h ready %b expected 1 8899aabb 0", c, bus3.rsp_valid, bus3.rsp_rdata, bus3.req_ready);
      end
    end
    bus3.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus3.rsp_ready = 1'b0;
    checks++; if (bus3.rsp_valid !== 1'b0 || bus3.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL lat3_release: got valid %b ready %b expected 0 1", bus3.rsp_valid, bus3.req_ready); end
  endtask

  task automatic test_reset_abort();
    int wr0;
    wr0 = wrCount1;
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_funct3 = 3'b001;
    bus1.req_addr = 32'h200; bus1.req_wdata = 32'h00005555; bus1.rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus1.req_ready !== 1'b0 || bus1.rsp_valid !== 1'b0 || bus1.mem_r_enable !== 1'b0 ||
        bus1.mem_w_enable !== 1'b0 || bus1.mem_addr !== 32'h0 || bus1.mem_wdata !== 32'h0 ||
        bus1.rsp_rdata !== 32'h0 || bus1.rsp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got ready %b valid %b r %b w %b addr %h expected all 0",
               bus1.req_ready, bus1.rsp_valid, bus1.mem_r_enable, bus1.mem_w_enable, bus1.mem_addr);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (wrCount1 !== wr0) begin errors++; $display("[TB] FAIL abort_no_write: got %0d writes expected 0", wrCount1 - wr0); end
    checks++; if (mem1[128] !== 32'hABCD3344) begin errors++; $display("[TB] FAIL abort_mem: got %h expected abcd3344", mem1[128]); end
    checks++; if (bus1.req_ready !== 1'b1 || bus1.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: got ready %b valid %b expected 1 0", bus1.req_ready, bus1.rsp_valid); end
  endtask

  task automatic test_monitors();
    checks++; if (bothHigh1 !== 0 || bothHigh3 !== 0) begin errors++; $display("[TB] FAIL strobe_overlap: got %0d/%0d expected 0/0", bothHigh1, bothHigh3); end
    checks++; if (badIdle1 !== 0) begin errors++; $display("[TB] FAIL idle_bus_zero: got %0d cycles expected 0", badIdle1); end
  endtask

  initial begin
    rst_n = 1'b0;
    preload = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_funct3 = '0;
    bus1.req_addr = '0; bus1.req_wdata = '0; bus1.rsp_ready = 1'b0;
    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_funct3 = '0;
    bus3.req_addr = '0; bus3.req_wdata = '0; bus3.rsp_ready = 1'b0;
    test_reset();
    test_loads();
    test_store_rmw();
    test_sw();
    test_errors();
    test_back_to_back();
    test_latency3();
    test_reset_abort();
    test_monitors();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
